// File: rtl/pulse_pkg.sv
// Shared types and default timing constants for the pulse_gen family.
package pulse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // 1 ms pulse width and 1 s max period at a 50 MHz clock.
    localparam int unsigned DUTY_DEF       = 50000;
    localparam int unsigned PERIOD_MAX_DEF = 50000000;

endpackage

// File: rtl/pulse_edge_wdog.sv
// Registers gen_pulse once, flags its falling edge, and runs a watchdog that
// expires on the PERIOD_MAX-th enabled cycle without a pulse edge.
module pulse_edge_wdog
    import pulse_pkg::*;
#(
    parameter int unsigned PERIOD_MAX = PERIOD_MAX_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic gen_pulse,
    input  logic wd_clr,
    input  logic wd_en,
    output logic fall,
    output logic expire
);

    localparam int unsigned WD_W = $clog2(PERIOD_MAX + 1);

    logic            gp_q, gp_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            rise;

    always_comb begin
        gp_d   = gen_pulse;
        rise   = gen_pulse & ~gp_q;
        fall   = ~gen_pulse & gp_q;
        // An edge in the final cycle restarts the count instead of expiring.
        expire = wd_en && !(rise || fall) && (wd_q == WD_W'(PERIOD_MAX - 1));
        wd_d   = wd_q;
        if (wd_clr || rise || fall) begin
            wd_d = '0;
        end else if (wd_en && (wd_q != WD_W'(PERIOD_MAX))) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gp_q <= 1'b0;
            wd_q <= '0;
        end else begin
            gp_q <= gp_d;
            wd_q <= wd_d;
        end
    end

endmodule

// File: rtl/pulse_burst_ctrl.sv
// Burst sequencer for pulse_gen: validates a request, runs the generator for
// cfg_count pulses, then parks it. All outputs registered; abort and watchdog.
module pulse_burst_ctrl
    import pulse_pkg::*;
#(
    parameter int unsigned N          = 26,
    parameter int unsigned DUTY       = DUTY_DEF,
    parameter int unsigned PERIOD_MAX = PERIOD_MAX_DEF,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [N-1:0]     cfg_interval,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             abort,
    output logic [N-1:0]     gen_period,
    output logic             gen_rst_n,
    input  logic             gen_pulse,
    output logic             busy,
    output logic [CNT_W-1:0] pulse_cnt,
    output logic             done,
    output logic             aborted,
    output logic             cfg_err,
    output logic             wdog_err
);

    state_t           state_q, state_d;
    logic [N-1:0]     period_q, period_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gen_rst_n_q, gen_rst_n_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             cfg_err_q, cfg_err_d;
    logic             wdog_err_q, wdog_err_d;

    logic             pulse_fall, wd_expire;
    logic [N:0]       req_sum;
    logic             req_bad;
    logic [CNT_W-1:0] cnt_inc;
    logic             stop;

    pulse_edge_wdog #(
        .PERIOD_MAX (PERIOD_MAX)
    ) u_edge_wdog (
        .clk       (clk),
        .reset_n   (reset_n),
        .gen_pulse (gen_pulse),
        .wd_clr    (state_q == ST_ARM),
        .wd_en     (state_q == ST_RUN),
        .fall      (pulse_fall),
        .expire    (wd_expire)
    );

    always_comb begin
        // One extra bit so a large interval cannot wrap past the limit.
        req_sum     = {1'b0, cfg_interval} + (N+1)'(DUTY);
        req_bad     = (cfg_interval == '0) || (cfg_count == '0) ||
                      (req_sum >= (N+1)'(PERIOD_MAX));
        cnt_inc     = cnt_q + CNT_W'(1);

        state_d     = state_q;
        period_d    = period_q;
        target_d    = target_q;
        cnt_d       = cnt_q;
        gen_rst_n_d = 1'b0;
        cfg_ready_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
        cfg_err_d   = 1'b0;
        wdog_err_d  = 1'b0;
        stop        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cfg_ready_d = 1'b1;
                if (cfg_valid && cfg_ready_q) begin
                    if (req_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        period_d    = cfg_interval;
                        target_d    = cfg_count;
                        cnt_d       = '0;
                        state_d     = ST_ARM;
                        cfg_ready_d = 1'b0;
                        busy_d      = 1'b1;
                    end
                end
            end
            ST_ARM: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    stop      = 1'b1;
                end else begin
                    state_d     = ST_RUN;
                    gen_rst_n_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            ST_RUN: begin
                gen_rst_n_d = 1'b1;
                busy_d      = 1'b1;
                if (abort) begin
                    aborted_d = 1'b1;
                    stop      = 1'b1;
                end else if (wd_expire) begin
                    aborted_d  = 1'b1;
                    wdog_err_d = 1'b1;
                    stop       = 1'b1;
                end else if (pulse_fall) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == target_q) begin
                        done_d = 1'b1;
                        stop   = 1'b1;
                    end
                end
            end
            default: begin
                stop = 1'b1;
            end
        endcase

        if (stop) begin
            state_d     = ST_IDLE;
            gen_rst_n_d = 1'b0;
            busy_d      = 1'b0;
            cfg_ready_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            period_q    <= '0;
            target_q    <= '0;
            cnt_q       <= '0;
            gen_rst_n_q <= 1'b0;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
            wdog_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            target_q    <= target_d;
            cnt_q       <= cnt_d;
            gen_rst_n_q <= gen_rst_n_d;
            cfg_ready_q <= cfg_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            cfg_err_q   <= cfg_err_d;
            wdog_err_q  <= wdog_err_d;
        end
    end

    assign cfg_ready  = cfg_ready_q;
    assign gen_period = period_q;
    assign gen_rst_n  = gen_rst_n_q;
    assign busy       = busy_q;
    assign pulse_cnt  = cnt_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign cfg_err    = cfg_err_q;
    assign wdog_err   = wdog_err_q;

endmodule

// File: tb/tb_pulse_burst_ctrl.sv
// Directed bench for pulse_burst_ctrl driving a behavioural pulse_gen
// (low for gen_period cycles, high for DUTY cycles, held idle by gen_rst_n).
module tb_pulse_burst_ctrl;

    localparam int N          = 8;
    localparam int DUTY       = 4;
    localparam int PERIOD_MAX = 64;
    localparam int CNT_W      = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [N-1:0]     cfg_interval;
    logic [CNT_W-1:0] cfg_count;
    logic             abort;
    logic [N-1:0]     gen_period;
    logic             gen_rst_n;
    logic             gen_pulse;
    logic             busy;
    logic [CNT_W-1:0] pulse_cnt;
    logic             done;
    logic             aborted;
    logic             cfg_err;
    logic             wdog_err;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_done, n_abort;
    bit rst_rose;
    bit gp_now, gp_prev;
    bit force_low = 1'b0;

    always #5 clk = ~clk;

    pulse_burst_ctrl #(
        .N          (N),
        .DUTY       (DUTY),
        .PERIOD_MAX (PERIOD_MAX),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_interval (cfg_interval),
        .cfg_count    (cfg_count),
        .abort        (abort),
        .gen_period   (gen_period),
        .gen_rst_n    (gen_rst_n),
        .gen_pulse    (gen_pulse),
        .busy         (busy),
        .pulse_cnt    (pulse_cnt),
        .done         (done),
        .aborted      (aborted),
        .cfg_err      (cfg_err),
        .wdog_err     (wdog_err)
    );

    // Behavioural pulse generator.
    int   pg_c, pg_nx;
    logic pg_out;

    always_comb begin
        pg_nx = (pg_c >= int'(gen_period) + DUTY - 1) ? 0 : pg_c + 1;
    end

    always @(posedge clk or negedge gen_rst_n) begin
        if (!gen_rst_n) begin
            pg_c   <= 0;
            pg_out <= 1'b0;
        end else begin
            pg_c   <= pg_nx;
            pg_out <= (pg_nx >= int'(gen_period));
        end
    end

    assign gen_pulse = pg_out & ~force_low;

    task automatic chk_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        gp_prev = gp_now;
        gp_now  = gen_pulse;
        if (done)      n_done++;
        if (aborted)   n_abort++;
        if (gen_rst_n) rst_rose = 1'b1;
    endtask

    task automatic clr_stats();
        n_done   = 0;
        n_abort  = 0;
        rst_rose = 1'b0;
    endtask

    task automatic wait_edge(input bit rise, input int budget, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (rise ? (gp_now && !gp_prev) : (!gp_now && gp_prev)) begin
                ok = 1'b1;
                break;
            end
        end
        chk_eq(tag, int'(ok), 1);
    endtask

    // Present one request for one cycle; returns at the sample after the handshake.
    task automatic send(input int iv, input int cnt);
        cfg_interval = N'(iv);
        cfg_count    = CNT_W'(cnt);
        cfg_valid    = 1'b1;
        step();
        cfg_valid    = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_eq({tag, "_ready"},  int'(cfg_ready), 1);
        chk_eq({tag, "_grst"},   int'(gen_rst_n), 0);
        chk_eq({tag, "_period"}, int'(gen_period), 0);
        chk_eq({tag, "_busy"},   int'(busy), 0);
        chk_eq({tag, "_cnt"},    int'(pulse_cnt), 0);
        chk_eq({tag, "_strb"},   int'({done, aborted, cfg_err, wdog_err}), 0);
    endtask

    initial begin
        int rise_cyc, t0;
        bit seen;

        reset_n      = 1'b0;
        cfg_valid    = 1'b0;
        cfg_interval = '0;
        cfg_count    = '0;
        abort        = 1'b0;
        clr_stats();
        repeat (3) step();
        chk_reset_vals("rst");
        reset_n = 1'b1;
        step();

        // 1: interval 10, three pulses of width DUTY, done after third fall.
        clr_stats();
        send(10, 3);
        chk_eq("t1_arm_busy",  int'(busy), 1);
        chk_eq("t1_arm_grst",  int'(gen_rst_n), 0);
        chk_eq("t1_arm_ready", int'(cfg_ready), 0);
        chk_eq("t1_period",    int'(gen_period), 10);
        for (int p = 1; p <= 3; p++) begin
            wait_edge(1'b1, 100, "t1_rise");
            rise_cyc = cyc;
            wait_edge(1'b0, 100, "t1_fall");
            chk_eq("t1_width", cyc - rise_cyc, DUTY);
        end
        chk_eq("t1_no_early_done", n_done + int'(done), 0);
        step();
        chk_eq("t1_done",  int'(done), 1);
        chk_eq("t1_cnt",   int'(pulse_cnt), 3);
        chk_eq("t1_grst",  int'(gen_rst_n), 0);
        chk_eq("t1_ready", int'(cfg_ready), 1);
        chk_eq("t1_busy",  int'(busy), 0);
        step();
        chk_eq("t1_done_1cyc", int'(done), 0);

        // 2: rejected requests, then the largest legal interval.
        clr_stats();
        send(0, 3);
        chk_eq("t2_err_iv0",  int'(cfg_err), 1);
        chk_eq("t2_busy_iv0", int'(busy), 0);
        step();
        chk_eq("t2_err_clr",  int'(cfg_err), 0);
        send(10, 0);
        chk_eq("t2_err_cnt0", int'(cfg_err), 1);
        step();
        send(60, 1);
        chk_eq("t2_err_iv60", int'(cfg_err), 1);
        chk_eq("t2_ready",    int'(cfg_ready), 1);
        chk_eq("t2_period_hold", int'(gen_period), 10);
        repeat (3) step();
        chk_eq("t2_grst_never", int'(rst_rose), 0);
        send(59, 1);
        chk_eq("t2_acc_err",  int'(cfg_err), 0);
        chk_eq("t2_acc_busy", int'(busy), 1);
        chk_eq("t2_period59", int'(gen_period), 59);
        wait_edge(1'b0, 200, "t2_fall");
        step();
        chk_eq("t2_done",   int'(done), 1);
        chk_eq("t2_cnt",    int'(pulse_cnt), 1);
        chk_eq("t2_no_wdog", n_abort, 0);

        // 3: abort while the second pulse is high.
        clr_stats();
        send(10, 5);
        wait_edge(1'b1, 100, "t3_rise1");
        wait_edge(1'b0, 100, "t3_fall1");
        wait_edge(1'b1, 100, "t3_rise2");
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_eq("t3_grst",    int'(gen_rst_n), 0);
        chk_eq("t3_aborted", int'(aborted), 1);
        chk_eq("t3_cnt",     int'(pulse_cnt), 1);
        chk_eq("t3_busy",    int'(busy), 0);
        chk_eq("t3_wdog",    int'(wdog_err), 0);
        repeat (20) step();
        chk_eq("t3_no_done", n_done, 0);
        chk_eq("t3_abort_1cyc", n_abort, 1);

        // 4: silent generator, watchdog fires PERIOD_MAX cycles into RUN.
        clr_stats();
        force_low = 1'b1;
        send(10, 2);
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            step();
            seen = gen_rst_n;
        end
        chk_eq("t4_run_entry", int'(seen), 1);
        t0 = cyc;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            step();
            seen = wdog_err;
        end
        chk_eq("t4_wdog_seen", int'(seen), 1);
        chk_eq("t4_wdog_lat",  cyc - t0, PERIOD_MAX);
        chk_eq("t4_aborted",   int'(aborted), 1);
        chk_eq("t4_cnt",       int'(pulse_cnt), 0);
        chk_eq("t4_grst",      int'(gen_rst_n), 0);
        chk_eq("t4_no_done",   n_done, 0);
        force_low = 1'b0;
        step();

        // 5a: abort in the same cycle as the final falling edge.
        clr_stats();
        send(10, 2);
        wait_edge(1'b1, 100, "t5_rise1");
        wait_edge(1'b0, 100, "t5_fall1");
        wait_edge(1'b1, 100, "t5_rise2");
        wait_edge(1'b0, 100, "t5_fall2");
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_eq("t5_aborted", int'(aborted), 1);
        chk_eq("t5_done",    int'(done), 0);
        chk_eq("t5_cnt",     int'(pulse_cnt), 1);
        repeat (3) step();
        chk_eq("t5_no_done", n_done, 0);

        // 5b: reset asserted mid-RUN.
        clr_stats();
        send(10, 3);
        wait_edge(1'b1, 100, "t5r_rise");
        wait_edge(1'b0, 100, "t5r_fall");
        repeat (3) step();
        chk_eq("t5r_running", int'(gen_rst_n), 1);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("t5r");
        step();
        reset_n = 1'b1;
        step();
        chk_eq("t5r_idle_busy", int'(busy), 0);
        chk_eq("t5r_no_strobe", n_done + n_abort, 0);

        // 6: valid held through a burst; next request taken when ready returns.
        clr_stats();
        cfg_interval = N'(10);
        cfg_count    = CNT_W'(1);
        cfg_valid    = 1'b1;
        step();
        chk_eq("t6_busy", int'(busy), 1);
        cfg_interval = N'(20);
        wait_edge(1'b0, 100, "t6_fall");
        chk_eq("t6_held_period", int'(gen_period), 10);
        chk_eq("t6_held_busy",   int'(busy), 1);
        step();
        chk_eq("t6_done",        int'(done), 1);
        chk_eq("t6_done_period", int'(gen_period), 10);
        chk_eq("t6_done_ready",  int'(cfg_ready), 1);
        step();
        cfg_valid = 1'b0;
        chk_eq("t6_reacc_busy",   int'(busy), 1);
        chk_eq("t6_reacc_period", int'(gen_period), 20);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_eq("t6_abort_arm", int'(aborted), 1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
